// File: rtl/hammer_judge.sv
// hammer_judge -- referee for a ten-hole whack-a-mole game.
//
// Watches the hammer switches, the mole-visible levels and the mole-escape
// levels. It decides hits, empty swings and fouls, and keeps a two-digit BCD
// score and a small life counter. It also runs the IDLE/PLAY/OVER game
// sequence.
//
// Parameters
//    LIVES_INIT  lives loaded at reset and at every game start (1..7)
//
// Ports
//    clk         system clock; all state changes on its rising edge
//    rst_n       asynchronous active-low reset
//    sw          raw hammer switches, one per hole, asynchronous to clk
//    mole_up     per-hole "mole visible" levels (clk domain)
//    mole_fail   per-hole escape levels (clk domain)
//    start       game start / restart request (clk domain)
//    hit_ack     one-cycle per-hole pulse back to the hole FSM on a hit
//    score_bcd   score as two BCD digits, [7:4] tens, [3:0] units
//    lives       remaining lives
//    game_state  00 IDLE, 01 PLAY, 10 OVER
//    foul        one-cycle pulse when several hammers swing together
module hammer_judge #(
   parameter int LIVES_INIT = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] sw,
   input  logic [9:0] mole_up,
   input  logic [9:0] mole_fail,
   input  logic       start,
   output logic [9:0] hit_ack,
   output logic [7:0] score_bcd,
   output logic [2:0] lives,
   output logic [1:0] game_state,
   output logic       foul
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      OVER = 2'b10
   } state_t;

   localparam logic [2:0] LIVES_RESET = 3'(LIVES_INIT);

   state_t     state;

   logic [9:0] sw_meta;
   logic [9:0] sw_sync;
   logic [9:0] sw_sync_d;
   logic [9:0] fail_d;
   logic       start_d;

   logic [9:0] sw_rise;
   logic [9:0] fail_rise;
   logic       start_rise;

   logic       one_swing;
   logic       multi_swing;
   logic       hit;
   logic       life_loss;

   // Two-flop synchronizer for the raw switches, followed by a delayed copy
   // of the synchronized level for edge detection. The mole and start inputs
   // are already in the clk domain, so they only need the one-cycle delayed
   // copy for their own edge detectors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta   <= '0;
         sw_sync   <= '0;
         sw_sync_d <= '0;
         fail_d    <= '0;
         start_d   <= 1'b0;
      end else begin
         sw_meta   <= sw;
         sw_sync   <= sw_meta;
         sw_sync_d <= sw_sync;
         fail_d    <= mole_fail;
         start_d   <= start;
      end
   end

   assign sw_rise    = sw_sync & ~sw_sync_d;
   assign fail_rise  = mole_fail & ~fail_d;
   assign start_rise = start & ~start_d;

   // Swing classification. Clearing the lowest set bit leaves zero only when
   // exactly one bit was set, which avoids a full population count.
   assign one_swing   = (sw_rise != '0) && ((sw_rise & (sw_rise - 10'd1)) == '0);
   assign multi_swing = (sw_rise != '0) && !one_swing;
   assign hit         = one_swing && (|(sw_rise & mole_up));

   // An empty swing, a foul and any escape all cost the same single life.
   // They are OR-ed so several in one cycle still cost only one.
   assign life_loss   = (one_swing && !hit) || multi_swing || (|fail_rise);

   // BCD increment that stops at 99 instead of rolling over.
   function automatic logic [7:0] bcd_inc(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'h99) begin
         result = value;
      end else if (value[3:0] == 4'd9) begin
         result = {value[7:4] + 4'd1, 4'd0};
      end else begin
         result = {value[7:4], value[3:0] + 4'd1};
      end
      return result;
   endfunction

   // Game sequencer with registered outputs. The pulses default to zero
   // every cycle, so hit_ack and foul can last only one clock. In PLAY, a
   // cycle that begins with lives already at zero is spent moving to OVER.
   // Swings in that cycle are not judged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         score_bcd <= 8'h00;
         lives     <= LIVES_RESET;
         hit_ack   <= '0;
         foul      <= 1'b0;
      end else begin
         hit_ack <= '0;
         foul    <= 1'b0;
         case (state)
            IDLE: begin
               if (start_rise) begin
                  state     <= PLAY;
                  score_bcd <= 8'h00;
                  lives     <= LIVES_RESET;
               end
            end
            PLAY: begin
               if (lives == 3'd0) begin
                  state <= OVER;
               end else begin
                  if (hit) begin
                     hit_ack   <= sw_rise;
                     score_bcd <= bcd_inc(score_bcd);
                  end
                  foul <= multi_swing;
                  if (life_loss) begin
                     lives <= lives - 3'd1;
                  end
               end
            end
            OVER: begin
               if (start_rise) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign game_state = state;

endmodule

// File: tb/tb_hammer_judge.sv
// tb_hammer_judge -- self-checking bench for hammer_judge.
//
// A behavioural game model runs beside the DUT. It keeps the score as a
// plain decimal integer, the lives as an integer and the game phase as
// 0/1/2, and derives each swing from the history of switch levels sampled at
// clock edges. Directed stimulus walks through the hit, empty-swing, foul,
// escape, carry, saturation, game-over and mid-game reset cases, with literal
// expectations at the key points.
module tb_hammer_judge;

   localparam int LIVES = 5;

   logic       clk;
   logic       rst_n;
   logic [9:0] sw;
   logic [9:0] mole_up;
   logic [9:0] mole_fail;
   logic       start;
   logic [9:0] hit_ack;
   logic [7:0] score_bcd;
   logic [2:0] lives;
   logic [1:0] game_state;
   logic       foul;

   int total = 0;
   int bad   = 0;

   hammer_judge #(.LIVES_INIT(LIVES)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw         (sw),
      .mole_up    (mole_up),
      .mole_fail  (mole_fail),
      .start      (start),
      .hit_ack    (hit_ack),
      .score_bcd  (score_bcd),
      .lives      (lives),
      .game_state (game_state),
      .foul       (foul)
   );

   // Free-running clock with a 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model state. The sampled-level history holds the switch levels seen at
   // the last three edges. A new level counts as a swing once it has been
   // the oldest-but-one sample while the oldest sample was still low.
   logic [9:0] samp0, samp1, samp2;
   logic [9:0] mf_prev;
   logic       st_prev;
   int         m_state, m_score, m_lives;
   logic [9:0] m_ack;
   logic       m_foul;

   int         nx_state, nx_score, nx_lives;
   logic [9:0] nx_ack;
   logic       nx_foul;
   logic [9:0] m_rise;
   logic [9:0] m_frise;
   logic       m_srise;
   int         n_rise;
   logic       m_hit;
   logic       m_lose;

   // The game rules, applied to the edges the model sees this cycle.
   always_comb begin
      m_rise   = samp1 & ~samp2;
      m_frise  = mole_fail & ~mf_prev;
      m_srise  = start & ~st_prev;
      n_rise   = $countones(m_rise);
      m_hit    = (n_rise == 1) && ((m_rise & mole_up) != '0);
      m_lose   = (n_rise >= 2) || ((n_rise == 1) && !m_hit) || (m_frise != '0);
      nx_state = m_state;
      nx_score = m_score;
      nx_lives = m_lives;
      nx_ack   = '0;
      nx_foul  = 1'b0;
      if (m_state == 0) begin
         if (m_srise) begin
            nx_state = 1;
            nx_score = 0;
            nx_lives = LIVES;
         end
      end else if (m_state == 1) begin
         if (m_lives == 0) begin
            nx_state = 2;
         end else begin
            if (m_hit) begin
               nx_ack   = m_rise;
               nx_score = (m_score < 99) ? m_score + 1 : 99;
            end
            nx_foul = (n_rise >= 2);
            if (m_lose) nx_lives = m_lives - 1;
         end
      end else begin
         if (m_srise) nx_state = 0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp0   <= '0;
         samp1   <= '0;
         samp2   <= '0;
         mf_prev <= '0;
         st_prev <= 1'b0;
         m_state <= 0;
         m_score <= 0;
         m_lives <= LIVES;
         m_ack   <= '0;
         m_foul  <= 1'b0;
      end else begin
         samp0   <= sw;
         samp1   <= samp0;
         samp2   <= samp1;
         mf_prev <= mole_fail;
         st_prev <= start;
         m_state <= nx_state;
         m_score <= nx_score;
         m_lives <= nx_lives;
         m_ack   <= nx_ack;
         m_foul  <= nx_foul;
      end
   end

   function automatic logic [7:0] to_bcd(input int value);
      logic [7:0] result;
      result[7:4] = 4'(value / 10);
      result[3:0] = 4'(value % 10);
      return result;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Literal expectations, applied to the DUT and to the model alike.
   task automatic expectAll(input string name, input int st, input int score,
                            input int lv, input int ack, input int fl);
      checkOutput({name, ".state"}, int'(game_state), st);
      checkOutput({name, ".score"}, int'(score_bcd), score);
      checkOutput({name, ".lives"}, int'(lives), lv);
      checkOutput({name, ".ack"}, int'(hit_ack), ack);
      checkOutput({name, ".foul"}, int'(foul), fl);
      checkOutput({name, ".model_state"}, m_state, st);
      checkOutput({name, ".model_score"}, int'(to_bcd(m_score)), score);
      checkOutput({name, ".model_lives"}, m_lives, lv);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One complete swing: press, wait until it has been judged, release and
   // wait long enough for the switch to re-arm.
   task automatic applyStimulus(input logic [9:0] mask);
      sw = mask;
      step(3);
      sw = '0;
      step(3);
   endtask

   task automatic pulseStart();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      sw        = '0;
      mole_up   = '0;
      mole_fail = '0;
      start     = 1'b0;
      fork
         begin
            // Reset values, then the first game with a hit on hole 3.
            step(2);
            expectAll("reset", 0, 8'h00, 5, 0, 0);
            rst_n = 1'b1;
            step(2);
            pulseStart();
            expectAll("start", 1, 8'h00, 5, 0, 0);
            mole_up = 10'h008;
            sw      = 10'h008;
            step(3);
            expectAll("hit3", 1, 8'h01, 5, 10'h008, 0);
            step(1);
            expectAll("hit3_end", 1, 8'h01, 5, 0, 0);
            sw = '0;
            step(3);

            // Empty swing on hole 7.
            mole_up = '0;
            sw      = 10'h080;
            step(3);
            expectAll("empty7", 1, 8'h01, 4, 0, 0);
            sw = '0;
            step(3);

            // Two hammers together: a foul even though one mole is up.
            mole_up = 10'h002;
            sw      = 10'h006;
            step(3);
            expectAll("foul", 1, 8'h01, 3, 0, 1);
            step(1);
            expectAll("foul_end", 1, 8'h01, 3, 0, 0);
            sw = '0;
            step(3);

            // A hit and an escape on the same edge: both take effect.
            mole_up = 10'h008;
            sw      = 10'h008;
            step(2);
            mole_fail = 10'h001;
            step(1);
            expectAll("hit_fail", 1, 8'h02, 2, 10'h008, 0);
            mole_fail = '0;
            sw        = '0;
            step(3);

            // Carry from 09 to 10, then saturation at 99.
            for (int i = 0; i < 7; i++) applyStimulus(10'h008);
            expectAll("score09", 1, 8'h09, 2, 0, 0);
            applyStimulus(10'h008);
            expectAll("score10", 1, 8'h10, 2, 0, 0);
            for (int i = 0; i < 89; i++) applyStimulus(10'h008);
            expectAll("score99", 1, 8'h99, 2, 0, 0);
            sw = 10'h008;
            step(3);
            expectAll("sat99", 1, 8'h99, 2, 10'h008, 0);
            sw = '0;
            step(3);

            // An empty swing and an escape together cost a single life.
            mole_up = '0;
            sw      = 10'h010;
            step(2);
            mole_fail = 10'h004;
            step(1);
            expectAll("empty_fail", 1, 8'h99, 1, 0, 0);
            mole_fail = '0;
            sw        = '0;
            step(3);

            // The last life goes to two escapes at once, then the game is over.
            mole_fail = 10'h021;
            step(1);
            expectAll("last_life", 1, 8'h99, 0, 0, 0);
            step(1);
            expectAll("over", 2, 8'h99, 0, 0, 0);
            mole_fail = '0;
            mole_up   = 10'h008;
            sw        = 10'h008;
            step(3);
            expectAll("over_swing", 2, 8'h99, 0, 0, 0);
            sw = '0;
            step(3);
            pulseStart();
            expectAll("to_idle", 0, 8'h99, 0, 0, 0);
            step(2);
            pulseStart();
            expectAll("restart", 1, 8'h00, 5, 0, 0);
            step(2);

            // Reset in the middle of a swing, with the switch held through
            // the release.
            sw = 10'h008;
            step(2);
            #2 rst_n = 1'b0;
            #1 expectAll("async_rst", 0, 8'h00, 5, 0, 0);
            @(negedge clk);
            rst_n = 1'b1;
            step(4);
            expectAll("post_rst", 0, 8'h00, 5, 0, 0);
            sw = '0;
            step(3);
         end
         begin
            // Every-cycle comparison of the DUT against the model.
            forever begin
               @(negedge clk);
               total++;
               if (int'(game_state) != m_state || score_bcd != to_bcd(m_score) ||
                   int'(lives) != m_lives || hit_ack != m_ack || foul != m_foul) begin
                  bad++;
                  $display("[TB] FAIL cycle: got st=%0d sc=%h lv=%0d ack=%h foul=%0b, expected st=%0d sc=%h lv=%0d ack=%h foul=%0b at t=%0t",
                           game_state, score_bcd, lives, hit_ack, foul,
                           m_state, to_bcd(m_score), m_lives, m_ack, m_foul, $time);
               end
            end
         end
      join_any
      disable fork;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hammer_judge.md
HAMMER_JUDGE -- requirements
Module: hammer_judge

Interface
REQ-001 The block SHALL have parameter LIVES_INIT, default 5, meaning the lives loaded at reset and at game start (range 1..7).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset; reset is asynchronous and active-low.
REQ-004 The block SHALL have port sw, input, 10, raw hammer switches, one per hole, asynchronous to clk.
REQ-005 The block SHALL have port mole_up, input, 10, per-hole "mole visible" levels from the mouse-hole FSMs, synchronous to clk.
REQ-006 The block SHALL have port mole_fail, input, 10, per-hole escape levels from the mouse-hole FSMs, synchronous to clk.
REQ-007 The block SHALL have port start, input, 1, game start/restart request, synchronous to clk.
REQ-008 The block SHALL have port hit_ack, output, 10, a one-cycle per-hole pulse returned to the mouse-hole FSMs on a valid hit.
REQ-009 The block SHALL have port score_bcd, output, 8, two BCD digits holding the score, with [7:4] tens and [3:0] units.
REQ-010 The block SHALL have port lives, output, 3, the remaining lives.
REQ-011 The block SHALL have port game_state, output, 2, the game state: 00 IDLE, 01 PLAY, 10 OVER.
REQ-012 The block SHALL have port foul, output, 1, a one-cycle pulse on a multi-hammer swing.

Function
REQ-013 Each sw bit SHALL pass through a 2-flop synchronizer, then a rising-edge detector (sw_rise = sync & ~sync_d).
REQ-014 mole_fail SHALL be rising-edge detected per bit (fail_rise); start SHALL be rising-edge detected (start_rise).
REQ-015 State transitions SHALL be: IDLE->PLAY on start_rise; PLAY->OVER on the edge after lives reaches 0; OVER->IDLE on start_rise; no other transitions.
REQ-016 On IDLE->PLAY, score_bcd SHALL load 8'h00 and lives SHALL load LIVES_INIT in the same edge.
REQ-017 In PLAY, when exactly one sw_rise bit i is set and mole_up[i]=1, the swing is a hit: hit_ack[i]=1 for one cycle and score increments by 1.
REQ-018 In PLAY, when exactly one sw_rise bit i is set and mole_up[i]=0, the swing is an empty swing: lives decrements and there is no ack.
REQ-019 In PLAY, when two or more sw_rise bits are set in the same cycle, foul SHALL pulse for one cycle, lives decrements, and there is no hit_ack and no score change.
REQ-020 In PLAY, when any fail_rise bit is set, lives SHALL decrement, regardless of how many holes fail.
REQ-021 Lives SHALL decrement by at most 1 per cycle, even if an empty swing or foul coincides with fail_rise.
REQ-022 Lives SHALL saturate at 0 and never wrap.
REQ-023 A hit coincident with fail_rise SHALL apply both the score increment and the single life decrement.
REQ-024 Score SHALL increment in BCD: units 9->0 with tens carry; 99 SHALL saturate at 99.
REQ-025 Latency: with E0 the first clk edge sampling a new sw level, sw_rise SHALL be valid between E1 and E2, and hit_ack/score/lives/foul SHALL update at E2.
REQ-026 In IDLE and OVER, sw_rise and fail_rise SHALL be ignored and hit_ack and foul SHALL be 0.
REQ-027 In OVER, score_bcd and lives SHALL hold their values.
REQ-028 All outputs SHALL be registered, with no combinational path from input to output.
REQ-029 A switch held high produces exactly one sw_rise; re-arming requires a low level for at least 2 cycles.

Reset
REQ-030 While rst_n=0, the outputs SHALL be: game_state=IDLE, score_bcd=8'h00, lives=LIVES_INIT, hit_ack=0, foul=0; all synchronizer and edge-detect flops SHALL be 0.
REQ-031 Reset asserted mid-PLAY SHALL abort the game immediately (asynchronous) and restore the REQ-030 values, with no pending hit_ack or foul emitted after release.
REQ-032 A switch held high through reset release SHALL produce one sw_rise in IDLE, which is ignored per REQ-026.

Verification
REQ-033 Reset, start pulse, mole_up[3]=1, sw[3] 0->1 -> game_state=01; at E2 hit_ack=10'h008 for one cycle; score_bcd=8'h01; lives=5.
REQ-034 PLAY, mole_up=0, sw[7] 0->1 -> no hit_ack; lives 5->4; score unchanged.
REQ-035 PLAY, sw[1] and sw[2] rise in the same cycle with mole_up[1]=1 -> foul pulse; hit_ack=0; lives-1; score unchanged.
REQ-036 PLAY, score=8'h09 then a hit -> 8'h10; score=8'h99 then a hit -> stays 8'h99.
REQ-037 PLAY, lives=1, mole_fail[0] and mole_fail[5] rise together -> lives=0 (not wrapping); next edge game_state=10; later swings ignored; start_rise -> IDLE; start_rise -> PLAY with score 00, lives 5.
REQ-038 rst_n pulsed low mid-PLAY during a swing -> outputs immediately at REQ-030 values; no hit_ack after release.
